// File: rtl/banked_regfile.sv
// Banked general-purpose register file for the fast-interrupt core.
// NUM_BANKS physical copies of the register set. irq_enter_i/irq_exit_i
// push and pop the active bank. Writes carry their own bank tag, so late
// writebacks land in the bank of the instruction that issued them.
// Optional feature macro: BANKED_RF_SP_SHARE_EN. When defined, x2 (sp) has a
// single physical copy that is shared by all banks.
module banked_regfile #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 5,
    parameter int unsigned NUM_BANKS    = 2,
    parameter int unsigned NUM_RD_PORTS = 2,
    localparam int unsigned BANK_W      = $clog2(NUM_BANKS)
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0]   rd_addr_i,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0]   rd_data_o,
    input  logic                                 wr_en_i,
    input  logic [ADDR_WIDTH-1:0]                wr_addr_i,
    input  logic [BANK_W-1:0]                    wr_bank_i,
    input  logic [DATA_WIDTH-1:0]                wr_data_i,
    input  logic                                 irq_enter_i,
    input  logic                                 irq_exit_i,
    output logic [BANK_W-1:0]                    cur_bank_o,
    output logic [BANK_W-1:0]                    depth_o,
    output logic                                 ovf_o,
    output logic                                 unf_o
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [BANK_W-1:0] MAX_DEPTH = BANK_W'(NUM_BANKS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        NESTED = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [BANK_W-1:0]   depth_q, depth_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;

    logic [DATA_WIDTH-1:0] regs [NUM_BANKS][NUM_REGS];
    logic                  wr_active;
    logic                  wr_bank_mem;

    assign wr_active = wr_en_i && (wr_addr_i != '0);

`ifdef BANKED_RF_SP_SHARE_EN
    localparam logic [ADDR_WIDTH-1:0] SP_ADDR = ADDR_WIDTH'(2);

    logic [DATA_WIDTH-1:0] sp_q;
    logic                  wr_is_sp;

    assign wr_is_sp    = wr_active && (wr_addr_i == SP_ADDR);
    assign wr_bank_mem = wr_active && !wr_is_sp;

    // Shared stack pointer: one copy, bank tag ignored
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sp_q <= '0;
        end else if (wr_is_sp) begin
            sp_q <= wr_data_i;
        end
    end
`else
    assign wr_bank_mem = wr_active;
`endif

    // Banked storage: synchronous clear, tagged write (x0 never written)
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    regs[b][r] <= '0;
                end
            end
        end else if (wr_bank_mem) begin
            regs[wr_bank_i][wr_addr_i] <= wr_data_i;
        end
    end

    // Read ports: combinational, with bypass from the write port
    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  bank_match;
        logic                  hit;

        assign addr = rd_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];

        // Select bypass, shared sp, or the active bank's entry
        always_comb begin
            bank_match = (wr_bank_i == depth_q);
`ifdef BANKED_RF_SP_SHARE_EN
            if (addr == SP_ADDR) begin
                bank_match = 1'b1;
            end
`endif
            hit  = wr_active && (wr_addr_i == addr) && bank_match;
            data = regs[depth_q][addr];
`ifdef BANKED_RF_SP_SHARE_EN
            if (addr == SP_ADDR) begin
                data = sp_q;
            end
`endif
            if (addr == '0) begin
                data = '0;
            end else if (hit) begin
                data = wr_data_i;
            end
        end

        assign rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] = data;
    end

    // Bank pointer state register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Bank pointer next state: saturating push/pop with sticky error flags
    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (irq_enter_i && !irq_exit_i) begin
            if (depth_q == MAX_DEPTH) begin
                ovf_d = 1'b1;
            end else begin
                depth_d = depth_q + BANK_W'(1);
            end
        end else if (irq_exit_i && !irq_enter_i) begin
            case (state_q)
                IDLE:    unf_d   = 1'b1;
                NESTED:  depth_d = depth_q - BANK_W'(1);
                default: depth_d = depth_q;
            endcase
        end
        state_d = (depth_d == '0) ? IDLE : NESTED;
    end

    assign cur_bank_o = depth_q;
    assign depth_o    = depth_q;
    assign ovf_o      = ovf_q;
    assign unf_o      = unf_q;

endmodule

// File: tb/tb_banked_regfile.sv
// Self-checking bench for banked_regfile: directed test-plan steps followed by
// randomized traffic compared against a behavioural register-file model.
module tb_banked_regfile;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NB = 2;
    localparam int unsigned NP = 2;
    localparam int unsigned BW = $clog2(NB);
    localparam int unsigned NR = 2 ** AW;

    logic               clk = 1'b0;
    logic               reset_i;
    logic [NP*AW-1:0]   rd_addr_i;
    logic [NP*DW-1:0]   rd_data_o;
    logic               wr_en_i;
    logic [AW-1:0]      wr_addr_i;
    logic [BW-1:0]      wr_bank_i;
    logic [DW-1:0]      wr_data_i;
    logic               irq_enter_i;
    logic               irq_exit_i;
    logic [BW-1:0]      cur_bank_o;
    logic [BW-1:0]      depth_o;
    logic               ovf_o;
    logic               unf_o;

    banked_regfile dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .rd_addr_i   (rd_addr_i),
        .rd_data_o   (rd_data_o),
        .wr_en_i     (wr_en_i),
        .wr_addr_i   (wr_addr_i),
        .wr_bank_i   (wr_bank_i),
        .wr_data_i   (wr_data_i),
        .irq_enter_i (irq_enter_i),
        .irq_exit_i  (irq_exit_i),
        .cur_bank_o  (cur_bank_o),
        .depth_o     (depth_o),
        .ovf_o       (ovf_o),
        .unf_o       (unf_o)
    );

    always #5 clk = ~clk;

`ifdef BANKED_RF_SP_SHARE_EN
    localparam bit SP_SHARED = 1'b1;
`else
    localparam bit SP_SHARED = 1'b0;
`endif

    // Reference model state
    logic [DW-1:0] m_mem [NB][NR];
    logic [DW-1:0] m_sp;
    int            m_depth;
    bit            m_ovf;
    bit            m_unf;

    int checks = 0;
    int errors = 0;

    function automatic logic [DW-1:0] exp_rd(input int a);
        bit shared;
        shared = SP_SHARED && (a == 2);
        if (a == 0) return '0;
        if (wr_en_i && wr_addr_i != '0 && int'(wr_addr_i) == a &&
            (int'(wr_bank_i) == m_depth || shared)) return wr_data_i;
        if (shared) return m_sp;
        return m_mem[m_depth][a];
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] port(input int p);
        return rd_data_o[p*DW +: DW];
    endfunction

    task automatic check_all();
        chk("cur_bank", DW'(cur_bank_o), DW'(m_depth));
        chk("depth", DW'(depth_o), DW'(m_depth));
        chk("ovf", DW'(ovf_o), DW'(m_ovf));
        chk("unf", DW'(unf_o), DW'(m_unf));
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("rd_data[%0d]", p), port(p),
                exp_rd(int'(rd_addr_i[p*AW +: AW])));
        end
    endtask

    task automatic eval();
        @(negedge clk);
        check_all();
    endtask

    // Advance one clock and apply the architectural rules to the model
    task automatic adv();
        @(posedge clk);
        if (reset_i) begin
            for (int b = 0; b < NB; b++)
                for (int r = 0; r < NR; r++)
                    m_mem[b][r] = '0;
            m_sp = '0; m_depth = 0; m_ovf = 0; m_unf = 0;
        end else begin
            if (wr_en_i && wr_addr_i != '0) begin
                if (SP_SHARED && wr_addr_i == AW'(2)) m_sp = wr_data_i;
                else m_mem[wr_bank_i][wr_addr_i] = wr_data_i;
            end
            if (irq_enter_i && !irq_exit_i) begin
                if (m_depth < NB - 1) m_depth++;
                else m_ovf = 1;
            end else if (irq_exit_i && !irq_enter_i) begin
                if (m_depth > 0) m_depth--;
                else m_unf = 1;
            end
        end
        #1;
    endtask

    task automatic drive(input bit we, input int wa, input int wb, input logic [DW-1:0] wd,
                         input int ra0, input int ra1, input bit ent, input bit ext);
        reset_i     = 1'b0;
        wr_en_i     = we;
        wr_addr_i   = AW'(wa);
        wr_bank_i   = BW'(wb);
        wr_data_i   = wd;
        rd_addr_i   = {AW'(ra1), AW'(ra0)};
        irq_enter_i = ent;
        irq_exit_i  = ext;
    endtask

    task automatic do_reset();
        drive(1, 9, 0, 32'hFFFF_FFFF, 0, 0, 1, 0);
        reset_i = 1'b1;
        adv();
        drive(0, 0, 0, '0, 0, 0, 0, 0);
    endtask

    task automatic step(input bit we, input int wa, input int wb, input logic [DW-1:0] wd,
                        input int ra0, input int ra1, input bit ent, input bit ext);
        drive(we, wa, wb, wd, ra0, ra1, ent, ext);
        eval();
        adv();
    endtask

    initial begin
        drive(0, 0, 0, '0, 0, 0, 0, 0);
        m_depth = 0; m_ovf = 0; m_unf = 0; m_sp = '0;
        for (int b = 0; b < NB; b++)
            for (int r = 0; r < NR; r++)
                m_mem[b][r] = '0;
        @(posedge clk); #1;

        // Reset, then all registers read zero
        do_reset();
        for (int i = 0; i < NR; i++) begin
            drive(0, 0, 0, '0, i, NR - 1 - i, 0, 0);
            eval();
            chk("reset_rd0", port(0), '0);
            adv();
        end
        chk("reset_bank", DW'(cur_bank_o), '0);

        // Same-cycle bypass, then stored value
        drive(1, 5, 0, 32'hDEAD_BEEF, 5, 0, 0, 0);
        eval();
        chk("bypass_x5", port(0), 32'hDEAD_BEEF);
        adv();
        drive(0, 0, 0, '0, 5, 5, 0, 0);
        eval();
        chk("stored_x5", port(0), 32'hDEAD_BEEF);
        adv();

        // Bank isolation across enter/exit
        step(1, 5, 0, 32'h11, 0, 0, 0, 0);
        step(0, 0, 0, '0, 5, 0, 1, 0);
        drive(0, 0, 0, '0, 5, 0, 0, 0);
        eval(); chk("bank1_x5", port(0), '0); adv();
        step(1, 5, 1, 32'h22, 0, 0, 0, 0);
        step(0, 0, 0, '0, 0, 0, 0, 1);
        drive(0, 0, 0, '0, 5, 0, 0, 0);
        eval(); chk("bank0_x5", port(0), 32'h11); adv();
        step(0, 0, 0, '0, 0, 0, 1, 0);
        drive(0, 0, 0, '0, 5, 0, 0, 0);
        eval(); chk("bank1_x5_again", port(0), 32'h22); adv();

        // Overflow / underflow saturation and simultaneous pulses
        do_reset();
        step(0, 0, 0, '0, 0, 0, 1, 0);
        step(0, 0, 0, '0, 0, 0, 1, 0);
        eval();
        chk("ovf_bank", DW'(cur_bank_o), 1);
        chk("ovf_flag", DW'(ovf_o), 1);
        adv();
        step(0, 0, 0, '0, 0, 0, 0, 1);
        step(0, 0, 0, '0, 0, 0, 0, 1);
        eval();
        chk("unf_bank", DW'(cur_bank_o), 0);
        chk("unf_flag", DW'(unf_o), 1);
        chk("ovf_sticky", DW'(ovf_o), 1);
        adv();
        step(0, 0, 0, '0, 0, 0, 1, 1);
        eval();
        chk("both_pulses_bank", DW'(cur_bank_o), 0);
        adv();

        // Write to inactive bank is not bypassed
        do_reset();
        step(0, 0, 0, '0, 0, 0, 1, 0);
        drive(1, 7, 0, 32'h33, 0, 7, 0, 0);
        eval(); chk("no_bypass_x7", port(1), '0); adv();
        step(0, 0, 0, '0, 0, 0, 0, 1);
        drive(0, 0, 0, '0, 0, 7, 0, 0);
        eval(); chk("bank0_x7", port(1), 32'h33); adv();

        // Shared stack pointer feature
        do_reset();
        step(1, 2, 0, 32'h8000, 0, 0, 0, 0);
        step(0, 0, 0, '0, 0, 0, 1, 0);
        drive(0, 0, 0, '0, 2, 2, 0, 0);
        eval();
        chk("sp_x2", port(0), SP_SHARED ? 32'h8000 : 32'h0);
        adv();

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            int wa;
            wa = int'($urandom_range(0, NR - 1));
            if ($urandom_range(0, 3) == 0) wa = int'($urandom_range(0, 3));
            drive($urandom_range(0, 1) == 1, wa, int'($urandom_range(0, NB - 1)), $urandom(),
                  ($urandom_range(0, 1) == 1) ? wa : int'($urandom_range(0, NR - 1)),
                  int'($urandom_range(0, NR - 1)),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
            reset_i = ($urandom_range(0, 149) == 0);
            eval();
            adv();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/banked_regfile.md
Name: banked_regfile

Overview:
- Next-generation GPR file for the fast-interrupt core, with NUM_BANKS physical copies of the architectural register set.
- An interrupt entry switches the ID stage to a fresh bank in one cycle, with no software save/restore. An interrupt exit returns to the previous bank.
- Combinational read ports with write-to-read bypass. One tagged write port, so late writebacks still land in the bank of the instruction that issued them.
- Sits in ID; the writeback stage drives the write port.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, architectural register address width; 2**ADDR_WIDTH registers per bank.
- NUM_BANKS, 2, physical banks; power of two, 2..8.
- NUM_RD_PORTS, 2, number of read ports.
- BANK_W, $clog2(NUM_BANKS), derived bank index width; not overridable.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset
- rd_addr_i  in  NUM_RD_PORTS*ADDR_WIDTH  read addresses, port p in slice [p*ADDR_WIDTH +: ADDR_WIDTH]
- rd_data_o  out  NUM_RD_PORTS*DATA_WIDTH  read data, same slicing
- wr_en_i  in  1  write enable
- wr_addr_i  in  ADDR_WIDTH  write address
- wr_bank_i  in  BANK_W  target bank of write (tag carried down pipe)
- wr_data_i  in  DATA_WIDTH  write data
- irq_enter_i  in  1  one-cycle pulse: push to next bank
- irq_exit_i  in  1  one-cycle pulse: pop to previous bank
- cur_bank_o  out  BANK_W  active bank for reads and for tagging new instructions
- depth_o  out  BANK_W  current nesting depth (equals cur_bank_o)
- ovf_o  out  1  sticky: enter refused at max depth
- unf_o  out  1  sticky: exit refused at depth 0

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (reset_i high at a posedge):
  - All registers in all banks become 0.
  - cur_bank_o=0, depth_o=0, ovf_o=0, unf_o=0.
  - Writes and irq pulses in that cycle are ignored.
  - Reset mid-nesting returns to bank 0 and discards all bank contents.
- Reads (combinational, zero latency):
  - rd_data[p] = bank[cur_bank][rd_addr[p]].
  - Address 0 always reads 0 in every bank.
  - Bypass: if wr_en_i, wr_addr_i!=0, wr_addr_i==rd_addr[p] and wr_bank_i==cur_bank_o, then rd_data[p]=wr_data_i.
  - A write to a non-active bank is never bypassed.
- Writes: at posedge, if wr_en_i and wr_addr_i!=0, bank[wr_bank_i][wr_addr_i] <= wr_data_i. Writes to x0 are dropped.
- Bank pointer state (IDLE = depth 0, NESTED = depth > 0), updated at posedge:
  - irq_enter_i only, depth < NUM_BANKS-1: depth, cur_bank += 1.
  - irq_enter_i only, depth == NUM_BANKS-1: no change; ovf_o <= 1.
  - irq_exit_i only, depth > 0: depth, cur_bank -= 1.
  - irq_exit_i only, depth == 0: no change; unf_o <= 1.
  - Both pulses in the same cycle: no change, no flag.
- Bank switch timing:
  - A switch takes effect from the next cycle; reads in the switching cycle still use the old bank.
  - A write tagged to the new bank in the same cycle as a switch commits normally; bypass follows the pre-switch cur_bank_o.
- No wrap-around of the bank pointer under any input sequence.
- Flags ovf_o and unf_o clear only on reset.

Optional Feature:
- Macro: BANKED_RF_SP_SHARE_EN.
- Defined: register x2 (sp) has a single physical copy shared by all banks.
  - Writes to x2 ignore wr_bank_i.
  - Reads of x2 return the shared copy from any bank.
  - x2 bypass ignores the bank-match term.
- Not defined: x2 is banked like every other register.

Test Plan:
- Reset, then read x0..x31 on both ports in bank 0 -> all 0; cur_bank_o=0, flags 0.
- Write x5=0xDEADBEEF bank 0 while port0 reads x5 -> same-cycle rd_data=0xDEADBEEF. Next cycle, with wr_en_i=0 -> 0xDEADBEEF.
- Write x5=0x11 bank 0; enter; read x5 -> 0. Write x5=0x22 bank 1; exit; read x5 -> 0x11. Enter again; read x5 -> 0x22.
- NUM_BANKS=2: enter, enter -> cur_bank_o=1, ovf_o=1. Then exit, exit -> cur_bank_o=0, unf_o=1. Enter+exit same cycle -> unchanged.
- Write x7=0x33 with wr_bank_i=0 while cur_bank_o=1 -> port reading x7 shows bank-1 value (no bypass); after exit, x7 reads 0x33.
- BANKED_RF_SP_SHARE_EN defined: write x2=0x8000 in bank 0; enter; read x2 -> 0x8000. Undefined: same sequence -> 0.
